// File: rtl/state_ctrl.sv
// Multi-cycle CPU sequencing FSM: FETCH -> EXEC1 -> [EXEC2] -> FETCH/HALTED,
// decoding memory strobes and write enables and counting retired instructions.
module state_ctrl (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        waitrequest_i,
    input  logic        exec2_req_i,
    input  logic        load_i,
    input  logic        store_i,
    input  logic        md_busy_i,
    input  logic        halt_i,
    output logic [1:0]  state_o,
    output logic        active_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        pc_wen_o,
    output logic        reg_wen_o,
    output logic [31:0] instr_count_o
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC1  = 2'd1,
        EXEC2  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        stall;
    logic        retire;
    logic [31:0] instr_count;

    assign stall = (waitrequest_i & (load_i | store_i)) | md_busy_i;

    // A cycle retires an instruction exactly when it enables the PC update.
    assign retire = pc_wen_o;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state       <= FETCH;
            instr_count <= 32'd0;
        end else begin
            state <= state_next;
            if (retire) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (!waitrequest_i) begin
                    state_next = EXEC1;
                end
            end
            EXEC1: begin
                if (exec2_req_i) begin
                    state_next = EXEC2;
                end else if (halt_i) begin
                    state_next = HALTED;
                end else begin
                    state_next = FETCH;
                end
            end
            EXEC2: begin
                if (!stall) begin
                    state_next = halt_i ? HALTED : FETCH;
                end
            end
            HALTED: state_next = HALTED;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        active_o    = 1'b1;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        pc_wen_o    = 1'b0;
        reg_wen_o   = 1'b0;
        case (state)
            FETCH: mem_read_o = 1'b1;
            EXEC1: begin
                pc_wen_o  = ~exec2_req_i;
                reg_wen_o = ~exec2_req_i;
            end
            EXEC2: begin
                // A load+store pair is illegal; both strobes simply follow their inputs.
                mem_read_o  = load_i;
                mem_write_o = store_i;
                pc_wen_o    = ~stall;
                reg_wen_o   = ~stall;
            end
            HALTED: active_o = 1'b0;
            default: active_o = 1'b1;
        endcase
    end

    assign state_o       = state;
    assign instr_count_o = instr_count;

endmodule

// File: tb/tb_state_ctrl.sv
// Directed bench for state_ctrl: linear scenario sequence with hand-computed
// expected state, strobes, enables and retired-instruction count.
module tb_state_ctrl;

    logic        clk;
    logic        reset_i;
    logic        waitrequest_i;
    logic        exec2_req_i;
    logic        load_i;
    logic        store_i;
    logic        md_busy_i;
    logic        halt_i;
    logic [1:0]  state_o;
    logic        active_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        pc_wen_o;
    logic        reg_wen_o;
    logic [31:0] instr_count_o;

    int checks   = 0;
    int failures = 0;

    state_ctrl dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .waitrequest_i (waitrequest_i),
        .exec2_req_i   (exec2_req_i),
        .load_i        (load_i),
        .store_i       (store_i),
        .md_busy_i     (md_busy_i),
        .halt_i        (halt_i),
        .state_o       (state_o),
        .active_o      (active_o),
        .mem_read_o    (mem_read_o),
        .mem_write_o   (mem_write_o),
        .pc_wen_o      (pc_wen_o),
        .reg_wen_o     (reg_wen_o),
        .instr_count_o (instr_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the inputs, then let the combinational decode settle before checking.
    task automatic drive(input logic w, input logic e2, input logic ld,
                         input logic st, input logic md, input logic h);
        waitrequest_i = w;
        exec2_req_i   = e2;
        load_i        = ld;
        store_i       = st;
        md_busy_i     = md;
        halt_i        = h;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic act,
                           input logic rd, input logic wr, input logic pcw,
                           input logic rgw, input logic [31:0] cnt);
        chk({tag, ".state"},  {30'd0, state_o}, {30'd0, st});
        chk({tag, ".active"}, {31'd0, active_o}, {31'd0, act});
        chk({tag, ".rd"},     {31'd0, mem_read_o}, {31'd0, rd});
        chk({tag, ".wr"},     {31'd0, mem_write_o}, {31'd0, wr});
        chk({tag, ".pcw"},    {31'd0, pc_wen_o}, {31'd0, pcw});
        chk({tag, ".rgw"},    {31'd0, reg_wen_o}, {31'd0, rgw});
        chk({tag, ".cnt"},    instr_count_o, cnt);
    endtask

    initial begin
        reset_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk_all("reset", 2'd0, 1, 1, 0, 0, 0, 32'd0);

        // Reset then a single-cycle ADDU.
        reset_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk_all("addu_fetch", 2'd0, 1, 1, 0, 0, 0, 32'd0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk_all("addu_exec1", 2'd1, 1, 0, 0, 1, 1, 32'd0);
        step();

        // Fetch wait-states.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            chk_all("fetch_wait", 2'd0, 1, 1, 0, 0, 0, 32'd1);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        chk_all("fetch_go", 2'd0, 1, 1, 0, 0, 0, 32'd1);
        step();

        // Stalled load; waitrequest in EXEC1 is ignored.
        drive(1, 1, 1, 0, 0, 0);
        chk_all("ld_exec1", 2'd1, 1, 0, 0, 0, 0, 32'd1);
        step();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, 0, 0, 0);
            chk_all("ld_stall", 2'd2, 1, 1, 0, 0, 0, 32'd1);
            step();
        end
        drive(0, 1, 1, 0, 0, 0);
        chk_all("ld_done", 2'd2, 1, 1, 0, 1, 1, 32'd1);
        step();

        // Divide busy for five EXEC2 cycles.
        drive(0, 0, 0, 0, 0, 0);
        chk_all("div_fetch", 2'd0, 1, 1, 0, 0, 0, 32'd2);
        step();
        drive(0, 1, 0, 0, 1, 0);
        chk_all("div_exec1", 2'd1, 1, 0, 0, 0, 0, 32'd2);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 0, 1, 0);
            chk_all("div_busy", 2'd2, 1, 0, 0, 0, 0, 32'd2);
            step();
        end
        drive(0, 1, 0, 0, 0, 0);
        chk_all("div_done", 2'd2, 1, 0, 0, 1, 1, 32'd2);
        step();

        // Illegal load+store in EXEC2: both strobes, otherwise a normal retire.
        drive(0, 0, 0, 0, 0, 0);
        step();
        drive(0, 1, 1, 1, 0, 0);
        chk_all("ldst_exec1", 2'd1, 1, 0, 0, 0, 0, 32'd3);
        step();
        drive(0, 1, 1, 1, 0, 0);
        chk_all("ldst_exec2", 2'd2, 1, 1, 1, 1, 1, 32'd3);
        step();

        // Load flag without exec2 request in EXEC1 is ignored.
        drive(0, 0, 0, 0, 0, 0);
        chk_all("ign_fetch", 2'd0, 1, 1, 0, 0, 0, 32'd4);
        step();
        drive(0, 0, 1, 0, 0, 0);
        chk_all("ign_exec1", 2'd1, 1, 0, 0, 1, 1, 32'd4);
        step();

        // jr to zero: halt on the final cycle.
        drive(0, 0, 0, 0, 0, 0);
        chk_all("halt_fetch", 2'd0, 1, 1, 0, 0, 0, 32'd5);
        step();
        drive(0, 0, 0, 0, 0, 1);
        chk_all("halt_exec1", 2'd1, 1, 0, 0, 1, 1, 32'd5);
        step();
        drive(1, 1, 1, 0, 1, 1);
        chk_all("halted_a", 2'd3, 0, 0, 0, 0, 0, 32'd6);
        step();
        drive(0, 0, 0, 1, 0, 0);
        chk_all("halted_b", 2'd3, 0, 0, 0, 0, 0, 32'd6);
        step();
        reset_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        chk_all("halted_rst_comb", 2'd3, 0, 0, 0, 0, 0, 32'd6);
        step();
        chk_all("halted_rst", 2'd0, 1, 1, 0, 0, 0, 32'd0);
        reset_i = 1'b0;

        // One ADDU, then reset in the middle of a busy stall.
        drive(0, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk_all("ms_fetch", 2'd0, 1, 1, 0, 0, 0, 32'd1);
        step();
        drive(0, 1, 0, 0, 1, 0);
        step();
        drive(0, 1, 0, 0, 1, 0);
        chk_all("ms_stall", 2'd2, 1, 0, 0, 0, 0, 32'd1);
        reset_i = 1'b1;
        step();
        chk_all("ms_reset", 2'd0, 1, 1, 0, 0, 0, 32'd0);
        reset_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
